pc_stack_ctrl: RTL and testbench

Call/return stack controller for the MCU program counter. It writes return addresses into scratch RAM on CALL or interrupt entry. On RET/RETIE it reads the top entry back and presents it as the return address that the PC source mux selects.
It owns the stack pointer, sequences the scratch RAM read/write handshake, and flags overflow and underflow.

---
 rtl/pc_stack_ctrl.sv | 165 ++++++++++++++++
 tb/tb_pc_stack_ctrl.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_stack_ctrl.sv
// pc_stack_ctrl: call/return stack controller for the MCU program counter.
// Return addresses live in an external scratch RAM (synchronous read,
// 1-cycle latency). The stack grows downward: a push pre-decrements SP and
// a pop post-increments it, with SP wrapping modulo 2**ADDR_W.
//
// Handshake: PUSH_REQ / POP_REQ are sampled only while BUSY is low (IDLE).
// A request seen while BUSY is high is dropped, not queued; the requester
// must re-assert it. RET_VALID is a one-cycle pulse marking a fresh RET_ADDR.
module pc_stack_ctrl #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 10
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              PUSH_REQ,
    input  logic              POP_REQ,
    input  logic [DATA_W-1:0] PC_IN,
    input  logic [DATA_W-1:0] SCR_DATA_OUT,
    output logic [ADDR_W-1:0] SCR_ADDR,
    output logic              SCR_WE,
    output logic [DATA_W-1:0] SCR_DATA_IN,
    output logic [DATA_W-1:0] RET_ADDR,
    output logic              RET_VALID,
    output logic              BUSY,
    output logic [ADDR_W-1:0] SP,
    output logic              STACK_EMPTY,
    output logic              STACK_FULL,
    output logic              OVERFLOW,
    output logic              UNDERFLOW,
    output logic [1:0]        STATE_DBG
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PUSH    = 2'd1,
        ST_POP_RD  = 2'd2,
        ST_POP_CAP = 2'd3
    } state_t;

    // Entry count is one bit wider than SP so "full" is distinguishable
    // from "empty" when SP has wrapped back to zero.
    localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

    state_t              state;
    logic [ADDR_W-1:0]   sp;
    logic [ADDR_W:0]     count;
    logic [DATA_W-1:0]   data_latch;
    logic [ADDR_W-1:0]   addr_q;
    logic                we_q;
    logic                busy_q;
    logic [DATA_W-1:0]   ret_addr_q;
    logic                ret_valid_q;
    logic                overflow_q;
    logic                underflow_q;
    logic                is_empty;
    logic                is_full;

    // Occupancy flags decoded straight from the entry count.
    always_comb begin
        is_empty = (count == '0);
        is_full  = (count == DEPTH);
    end

    // Single FSM: state, stack pointer, count, and all registered outputs.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state       <= ST_IDLE;
            sp          <= '0;
            count       <= '0;
            data_latch  <= '0;
            addr_q      <= '0;
            we_q        <= 1'b0;
            busy_q      <= 1'b0;
            ret_addr_q  <= '0;
            ret_valid_q <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            // RET_VALID is a single-cycle strobe unless re-armed below.
            ret_valid_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    // In IDLE the RAM address follows SP.
                    addr_q <= sp;
                    we_q   <= 1'b0;
                    busy_q <= 1'b0;
                    if (PUSH_REQ) begin
                        // Push wins over a simultaneous pop; the pop is dropped.
                        if (!is_full) begin
                            data_latch <= PC_IN;
                            addr_q     <= sp - 1'b1;
                            we_q       <= 1'b1;
                            busy_q     <= 1'b1;
                            state      <= ST_PUSH;
                        end else begin
                            overflow_q <= 1'b1;
                        end
                    end else if (POP_REQ) begin
                        if (!is_empty) begin
                            addr_q <= sp;
                            busy_q <= 1'b1;
                            state  <= ST_POP_RD;
                        end else begin
                            underflow_q <= 1'b1;
                        end
                    end
                end

                ST_PUSH: begin
                    // The write strobe lasts exactly this one cycle.
                    sp     <= sp - 1'b1;
                    count  <= count + 1'b1;
                    addr_q <= sp - 1'b1;
                    we_q   <= 1'b0;
                    busy_q <= 1'b0;
                    state  <= ST_IDLE;
                end

                ST_POP_RD: begin
                    // The RAM registers SCR_ADDR on this edge; data is
                    // available during POP_CAP.
                    addr_q <= sp;
                    we_q   <= 1'b0;
                    busy_q <= 1'b1;
                    state  <= ST_POP_CAP;
                end

                ST_POP_CAP: begin
                    ret_addr_q  <= SCR_DATA_OUT;
                    ret_valid_q <= 1'b1;
                    sp          <= sp + 1'b1;
                    count       <= count - 1'b1;
                    addr_q      <= sp + 1'b1;
                    we_q        <= 1'b0;
                    busy_q      <= 1'b0;
                    state       <= ST_IDLE;
                end

                default: begin
                    addr_q <= sp;
                    we_q   <= 1'b0;
                    busy_q <= 1'b0;
                    state  <= ST_IDLE;
                end
            endcase
        end
    end

    // Output wiring; every value below comes from a flop or the count decode.
    always_comb begin
        SCR_ADDR    = addr_q;
        SCR_WE      = we_q;
        SCR_DATA_IN = data_latch;
        RET_ADDR    = ret_addr_q;
        RET_VALID   = ret_valid_q;
        BUSY        = busy_q;
        SP          = sp;
        STACK_EMPTY = is_empty;
        STACK_FULL  = is_full;
        OVERFLOW    = overflow_q;
        UNDERFLOW   = underflow_q;
        STATE_DBG   = state;
    end

endmodule

// File: tb/tb_pc_stack_ctrl.sv
// Bench for pc_stack_ctrl: directed vector table for reset, push/pop timing,
// underflow, priority and abandon-on-reset, then a fill-to-full sequence,
// overflow, and a random push/pop run against a reference stack. Popped
// return addresses are checked by a scoreboard queue.
module tb_pc_stack_ctrl;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 10;

    logic              CLK;
    logic              RST_N;
    logic              PUSH_REQ;
    logic              POP_REQ;
    logic [DATA_W-1:0] PC_IN;
    logic [DATA_W-1:0] SCR_DATA_OUT;
    logic [ADDR_W-1:0] SCR_ADDR;
    logic              SCR_WE;
    logic [DATA_W-1:0] SCR_DATA_IN;
    logic [DATA_W-1:0] RET_ADDR;
    logic              RET_VALID;
    logic              BUSY;
    logic [ADDR_W-1:0] SP;
    logic              STACK_EMPTY;
    logic              STACK_FULL;
    logic              OVERFLOW;
    logic              UNDERFLOW;
    logic [1:0]        STATE_DBG;

    int checks = 0;
    int errors = 0;

    logic [DATA_W-1:0] exp_q[$];
    logic [DATA_W-1:0] model_stk[$];
    logic [DATA_W-1:0] sb_e;
    logic [DATA_W-1:0] mem [256];

    pc_stack_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .CLK          (CLK),
        .RST_N        (RST_N),
        .PUSH_REQ     (PUSH_REQ),
        .POP_REQ      (POP_REQ),
        .PC_IN        (PC_IN),
        .SCR_DATA_OUT (SCR_DATA_OUT),
        .SCR_ADDR     (SCR_ADDR),
        .SCR_WE       (SCR_WE),
        .SCR_DATA_IN  (SCR_DATA_IN),
        .RET_ADDR     (RET_ADDR),
        .RET_VALID    (RET_VALID),
        .BUSY         (BUSY),
        .SP           (SP),
        .STACK_EMPTY  (STACK_EMPTY),
        .STACK_FULL   (STACK_FULL),
        .OVERFLOW     (OVERFLOW),
        .UNDERFLOW    (UNDERFLOW),
        .STATE_DBG    (STATE_DBG)
    );

    // Clock
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Scratch RAM model: synchronous write, synchronous read with 1-cycle latency
    always @(posedge CLK) begin
        if (SCR_WE) mem[SCR_ADDR] <= SCR_DATA_IN;
        SCR_DATA_OUT <= mem[SCR_ADDR];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard: every RET_VALID pulse must match the oldest expected address
    always @(negedge CLK) begin
        if (RET_VALID === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL ret_unexpected: got RET_VALID with RET_ADDR 0x%0h, expected no pulse", RET_ADDR);
            end else begin
                sb_e = exp_q.pop_front();
                check("ret_addr_sb", 32'(RET_ADDR), 32'(sb_e));
            end
        end
    end

    // Watchdog
    initial begin
        #200000;
        errors++;
        $display("FAIL timeout: simulation did not finish");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "timeout");
    end

    typedef struct {
        int rst_n; int push; int pop; int pc;
        int sb; int sb_val;
        int sp; int we; int addr; int din; int busy;
        int empty; int full; int rv; int ra; int ov; int ud;
    } vec_t;

    localparam int NV = 21;
    vec_t vec [NV];

    task automatic do_push(input logic [DATA_W-1:0] pc, input logic [ADDR_W-1:0] exp_addr, input bit chk);
        PUSH_REQ = 1'b1;
        PC_IN    = pc;
        @(posedge CLK); #1;
        PUSH_REQ = 1'b0;
        if (chk) begin
            check("push_we", 32'(SCR_WE), 1);
            check("push_addr", 32'(SCR_ADDR), 32'(exp_addr));
            check("push_din", 32'(SCR_DATA_IN), 32'(pc));
        end
        @(posedge CLK); #1;
        model_stk.push_back(pc);
    endtask

    task automatic do_pop();
        int lat;
        exp_q.push_back(model_stk.pop_back());
        POP_REQ = 1'b1;
        @(posedge CLK); #1;
        POP_REQ = 1'b0;
        lat = 1;
        while (RET_VALID !== 1'b1 && lat < 8) begin
            @(posedge CLK); #1;
            lat++;
        end
        check("pop_latency", 32'(lat), 3);
        @(posedge CLK); #1;
        check("ret_valid_pulse", 32'(RET_VALID), 0);
    endtask

    initial begin
        //        rst psh pop pc      sb sbv     sp     we addr   din     bsy emp ful rv ra      ov ud
        vec[0]  = '{0, 0, 0, 0,      0, 0,      'h00, 0, 'h00, 0,      0, 1, 0, 0, 0,      0, 0};
        vec[1]  = '{0, 0, 0, 0,      0, 0,      'h00, 0, 'h00, 0,      0, 1, 0, 0, 0,      0, 0};
        vec[2]  = '{1, 0, 0, 0,      0, 0,      'h00, 0, 'h00, 0,      0, 1, 0, 0, 0,      0, 0};
        vec[3]  = '{1, 1, 0, 'h155,  0, 0,      'h00, 1, 'hFF, 'h155,  1, 1, 0, 0, 0,      0, 0};
        vec[4]  = '{1, 0, 0, 0,      0, 0,      'hFF, 0, 'hFF, 0,      0, 0, 0, 0, 0,      0, 0};
        vec[5]  = '{1, 1, 0, 'h2AA,  0, 0,      'hFF, 1, 'hFE, 'h2AA,  1, 0, 0, 0, 0,      0, 0};
        vec[6]  = '{1, 0, 0, 0,      0, 0,      'hFE, 0, 'hFE, 0,      0, 0, 0, 0, 0,      0, 0};
        vec[7]  = '{1, 0, 1, 0,      1, 'h2AA,  'hFE, 0, 'hFE, 0,      1, 0, 0, 0, 0,      0, 0};
        vec[8]  = '{1, 0, 0, 0,      0, 0,      'hFE, 0, 'hFE, 0,      1, 0, 0, 0, 0,      0, 0};
        vec[9]  = '{1, 0, 0, 0,      0, 0,      'hFF, 0, 'hFF, 0,      0, 0, 0, 1, 'h2AA,  0, 0};
        vec[10] = '{1, 0, 1, 0,      1, 'h155,  'hFF, 0, 'hFF, 0,      1, 0, 0, 0, 'h2AA,  0, 0};
        vec[11] = '{1, 0, 0, 0,      0, 0,      'hFF, 0, 'hFF, 0,      1, 0, 0, 0, 'h2AA,  0, 0};
        vec[12] = '{1, 0, 0, 0,      0, 0,      'h00, 0, 'h00, 0,      0, 1, 0, 1, 'h155,  0, 0};
        vec[13] = '{1, 0, 1, 0,      0, 0,      'h00, 0, 'h00, 0,      0, 1, 0, 0, 'h155,  0, 1};
        vec[14] = '{1, 0, 0, 0,      0, 0,      'h00, 0, 'h00, 0,      0, 1, 0, 0, 'h155,  0, 1};
        vec[15] = '{1, 1, 1, 'h3C3,  0, 0,      'h00, 1, 'hFF, 'h3C3,  1, 1, 0, 0, 'h155,  0, 1};
        vec[16] = '{1, 0, 1, 0,      0, 0,      'hFF, 0, 'hFF, 0,      0, 0, 0, 0, 'h155,  0, 1};
        vec[17] = '{1, 0, 0, 0,      0, 0,      'hFF, 0, 'hFF, 0,      0, 0, 0, 0, 'h155,  0, 1};
        vec[18] = '{1, 0, 1, 0,      0, 0,      'hFF, 0, 'hFF, 0,      1, 0, 0, 0, 'h155,  0, 1};
        vec[19] = '{0, 0, 0, 0,      0, 0,      'h00, 0, 'h00, 0,      0, 1, 0, 0, 0,      0, 0};
        vec[20] = '{1, 0, 0, 0,      0, 0,      'h00, 0, 'h00, 0,      0, 1, 0, 0, 0,      0, 0};

        RST_N    = 1'b0;
        PUSH_REQ = 1'b0;
        POP_REQ  = 1'b0;
        PC_IN    = '0;

        // Directed vectors: each row is one clock, checked 1 time unit after the edge
        for (int i = 0; i < NV; i++) begin
            RST_N    = vec[i].rst_n[0];
            PUSH_REQ = vec[i].push[0];
            POP_REQ  = vec[i].pop[0];
            PC_IN    = vec[i].pc[DATA_W-1:0];
            if (vec[i].sb != 0) exp_q.push_back(vec[i].sb_val[DATA_W-1:0]);
            @(posedge CLK); #1;
            check($sformatf("v%0d_sp", i),    32'(SP),          vec[i].sp);
            check($sformatf("v%0d_we", i),    32'(SCR_WE),      vec[i].we);
            check($sformatf("v%0d_addr", i),  32'(SCR_ADDR),    vec[i].addr);
            if (vec[i].we != 0)
                check($sformatf("v%0d_din", i), 32'(SCR_DATA_IN), vec[i].din);
            check($sformatf("v%0d_busy", i),  32'(BUSY),        vec[i].busy);
            check($sformatf("v%0d_empty", i), 32'(STACK_EMPTY), vec[i].empty);
            check($sformatf("v%0d_full", i),  32'(STACK_FULL),  vec[i].full);
            check($sformatf("v%0d_rv", i),    32'(RET_VALID),   vec[i].rv);
            check($sformatf("v%0d_ra", i),    32'(RET_ADDR),    vec[i].ra);
            check($sformatf("v%0d_ovf", i),   32'(OVERFLOW),    vec[i].ov);
            check($sformatf("v%0d_udf", i),   32'(UNDERFLOW),   vec[i].ud);
        end
        PUSH_REQ = 1'b0;
        POP_REQ  = 1'b0;

        // Fill the whole stack with PC_IN = index
        for (int i = 0; i < 256; i++) begin
            do_push(10'(i), 8'(255 - i), (i == 0 || i == 128 || i == 255));
        end
        check("fill_full", 32'(STACK_FULL), 1);
        check("fill_empty", 32'(STACK_EMPTY), 0);
        check("fill_sp", 32'(SP), 0);
        check("fill_ovf", 32'(OVERFLOW), 0);

        // One push too many: overflow, no write, SP unchanged
        PUSH_REQ = 1'b1;
        PC_IN    = 10'h3FF;
        @(posedge CLK); #1;
        PUSH_REQ = 1'b0;
        check("ovf_set", 32'(OVERFLOW), 1);
        check("ovf_no_we", 32'(SCR_WE), 0);
        check("ovf_busy", 32'(BUSY), 0);
        check("ovf_sp", 32'(SP), 0);
        @(posedge CLK); #1;
        check("ovf_no_we2", 32'(SCR_WE), 0);
        check("ovf_sticky", 32'(OVERFLOW), 1);

        // Pop from full returns the last pushed value
        check("model_top", 32'(model_stk[model_stk.size()-1]), 'h0FF);
        do_pop();
        check("pop_full_ra", 32'(RET_ADDR), 'h0FF);
        check("pop_full_sp", 32'(SP), 'h01);
        check("pop_full_notfull", 32'(STACK_FULL), 0);

        // Random push/pop run against the reference stack
        for (int n = 0; n < 30; n++) begin
            int sz;
            sz = model_stk.size();
            if (($urandom_range(0, 1) == 0 && sz < 256) || sz == 0) begin
                do_push(10'($urandom_range(0, 1023)), 8'(255 - sz), 1'b1);
            end else begin
                do_pop();
            end
            sz = model_stk.size();
            check("rand_sp", 32'(SP), 32'(8'(256 - sz)));
            check("rand_empty", 32'(STACK_EMPTY), 32'(sz == 0));
        end

        repeat (4) @(posedge CLK);
        #1;
        check("sb_drained", 32'(exp_q.size()), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
